// File: rtl/regfile_reader.sv
// Register-file dump engine: walks every register address, presents each value on a
// valid/ready stream and, with REGFILE_READER_CHECKSUM_EN defined, sums accepted entries.
module regfile_reader #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_index,
   output logic [DATA_W-1:0] out_data,
   output logic [DATA_W-1:0] checksum
);

   typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] out_index_q;
   logic [DATA_W-1:0] out_data_q;
   logic              last_idx;
   logic              handshake;

   assign last_idx  = (idx_q == {ADDR_W{1'b1}});
   assign handshake = (state_q == StSend) && out_ready;

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRead;
         StRead:  state_d = StSend;
         StSend:  if (out_ready) state_d = last_idx ? StDone : StRead;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy      = (state_q != StIdle);
      done      = (state_q == StDone);
      out_valid = (state_q == StSend);
      rf_addr   = '0;
      if (state_q == StRead || state_q == StSend) rf_addr = idx_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q       <= '0;
         out_index_q <= '0;
         out_data_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: if (start) idx_q <= '0;
            StRead: begin
               out_index_q <= idx_q;
               // Register 0 is architecturally zero, whatever the array returns.
               out_data_q  <= (idx_q == '0) ? '0 : rf_data;
            end
            StSend: if (out_ready && !last_idx) idx_q <= idx_q + 1'b1;
            default: ;
         endcase
      end
   end

   assign out_index = out_index_q;
   assign out_data  = out_data_q;

`ifdef REGFILE_READER_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q;

   always_ff @(posedge clk) begin
      if (rst)                             checksum_q <= '0;
      else if (state_q == StIdle && start) checksum_q <= '0;
      else if (handshake)                  checksum_q <= checksum_q + out_data_q;
   end

   assign checksum = checksum_q;
`else
   logic unused_handshake;
   assign unused_handshake = handshake;
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_regfile_reader.sv
// Self-checking bench for regfile_reader: table of dump scenarios against a queue-based
// reference model, plus hand-written reset-abort and restart sequences.
module tb_regfile_reader;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int NREG   = 1 << ADDR_W;
   localparam int BUDGET = 3000;

   logic              clk = 1'b0;
   logic              rst, start, out_ready;
   logic              busy, done, out_valid;
   logic [ADDR_W-1:0] rf_addr, out_index;
   logic [DATA_W-1:0] rf_data, out_data, checksum;
   logic [DATA_W-1:0] regs [NREG];

   always #5 clk = ~clk;
   assign rf_data = regs[rf_addr];

   regfile_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .rf_addr   (rf_addr),
      .rf_data   (rf_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_index (out_index),
      .out_data  (out_data),
      .checksum  (checksum)
   );

   typedef struct {
      string       name;
      int          fill;        // 0: reg[i]=i+1 (reg0=FFFF_FFFF), 1: all 8000_0000, 2: random
      int          ready_mode;  // 0: always 1, 1: 1,0,0 repeating, 2: random
      int          restart_at;  // index at which start is pulsed again, -1 for none
      logic [31:0] exp_chk;     // used unless fill is random
      bit          timing;      // check exact edge timing (ready tied high)
   } vec_t;

   int n_pass = 0, n_total = 0;

   int               got_idx[$];
   logic [DATA_W-1:0] got_data[$];
   int done_cnt, done_edge, first_valid, idle_edge, stab_err, addr_err, busy_err;
   bit timed_out;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [DATA_W-1:0] chk_exp(input logic [DATA_W-1:0] v);
`ifdef REGFILE_READER_CHECKSUM_EN
      return v;
`else
      return '0;
`endif
   endfunction

   // Reference: entry i carries reg[i], except entry 0 which is always zero.
   function automatic logic [DATA_W-1:0] model_data(input int i);
      return (i == 0) ? '0 : regs[i];
   endfunction

   function automatic logic [DATA_W-1:0] model_sum();
      logic [DATA_W-1:0] s = '0;
      for (int i = 0; i < NREG; i++) s += model_data(i);
      return s;
   endfunction

   task automatic fill_regs(input int fill);
      for (int i = 0; i < NREG; i++) begin
         case (fill)
            0:       regs[i] = (i == 0) ? 32'hFFFF_FFFF : 32'(i + 1);
            1:       regs[i] = 32'h8000_0000;
            default: regs[i] = $urandom;
         endcase
      end
   endtask

   // Starts a dump and plays the consumer until the block returns to idle.
   task automatic do_dump(input int ready_mode, input int restart_at);
      int cyc = 0, send_k = 0, pidx = 0;
      bit pv = 0, pr = 0, r;
      logic [DATA_W-1:0] pdata = '0;
      got_idx.delete(); got_data.delete();
      done_cnt = 0; done_edge = -1; first_valid = -1; idle_edge = -1;
      stab_err = 0; addr_err = 0; busy_err = 0; timed_out = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (cyc < BUDGET) begin
         if (done) begin
            done_cnt++; done_edge = cyc;
            if (!busy) busy_err++;
            if (rf_addr != '0) addr_err++;
         end
         if (!busy) begin
            idle_edge = cyc;
            if (rf_addr != '0) addr_err++;
            break;
         end
         if (out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (rf_addr != out_index) addr_err++;
            if (pv && !pr && (int'(out_index) != pidx || out_data != pdata)) stab_err++;
            case (ready_mode)
               0:       r = 1'b1;
               1:       r = (send_k % 3 == 0);
               default: r = 1'($urandom_range(0, 1));
            endcase
            send_k++;
            if (restart_at >= 0 && int'(out_index) == restart_at) start = 1'b1;
         end else begin
            r = 1'($urandom_range(0, 1));
            if (!done && int'(rf_addr) != got_idx.size()) addr_err++;
         end
         out_ready = r;
         if (out_valid && r) begin
            got_idx.push_back(int'(out_index));
            got_data.push_back(out_data);
         end
         pv = out_valid; pr = r; pidx = int'(out_index); pdata = out_data;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      timed_out = (cyc >= BUDGET);
      out_ready = 1'b0;
   endtask

   task automatic check_entries(input string name);
      int n;
      check({name, ".timeout"}, 64'(timed_out), 64'd0);
      check({name, ".count"}, 64'(got_idx.size()), 64'(NREG));
      n = (got_idx.size() < NREG) ? got_idx.size() : NREG;
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s.idx%0d", name, i), 64'(got_idx[i]), 64'(i));
         check($sformatf("%s.data%0d", name, i), 64'(got_data[i]), 64'(model_data(i)));
      end
      check({name, ".done_cnt"}, 64'(done_cnt), 64'd1);
      check({name, ".stable"}, 64'(stab_err), 64'd0);
      check({name, ".rf_addr"}, 64'(addr_err), 64'd0);
      check({name, ".done_busy"}, 64'(busy_err), 64'd0);
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = '{"inc_ready1", 0, 0, -1, 32'h0000_020F, 1'b1};
      vecs[1] = '{"inc_toggle", 0, 1, -1, 32'h0000_020F, 1'b0};
      vecs[2] = '{"restart5",   0, 0,  5, 32'h0000_020F, 1'b1};
      vecs[3] = '{"wrap",       1, 0, -1, 32'h8000_0000, 1'b1};
      vecs[4] = '{"random",     2, 2, -1, 32'h0,         1'b0};

      rst = 1'b1; start = 1'b1; out_ready = 1'b1;
      fill_regs(0);
      repeat (3) @(posedge clk);
      #1;
      check("rst.busy", 64'(busy), 64'd0);
      check("rst.done", 64'(done), 64'd0);
      check("rst.valid", 64'(out_valid), 64'd0);
      check("rst.index", 64'(out_index), 64'd0);
      check("rst.data", 64'(out_data), 64'd0);
      check("rst.chk", 64'(checksum), 64'd0);
      check("rst.addr", 64'(rf_addr), 64'd0);
      rst = 1'b0; start = 1'b0;

      // out_ready high while idle must not start or disturb anything.
      repeat (3) @(posedge clk);
      #1;
      check("idle.busy", 64'(busy), 64'd0);
      check("idle.valid", 64'(out_valid), 64'd0);

      for (int v = 0; v < 5; v++) begin
         logic [DATA_W-1:0] want;
         fill_regs(vecs[v].fill);
         want = (vecs[v].fill == 2) ? model_sum() : vecs[v].exp_chk;
         do_dump(vecs[v].ready_mode, vecs[v].restart_at);
         check_entries(vecs[v].name);
         check({vecs[v].name, ".chk"}, 64'(checksum), 64'(chk_exp(want)));
         if (vecs[v].timing) begin
            check({vecs[v].name, ".first_valid"}, 64'(first_valid), 64'd1);
            check({vecs[v].name, ".done_edge"}, 64'(done_edge), 64'd64);
            check({vecs[v].name, ".idle_edge"}, 64'(idle_edge), 64'd65);
         end
         repeat (3) @(posedge clk);
         #1;
         check({vecs[v].name, ".chk_hold"}, 64'(checksum), 64'(chk_exp(want)));
         check({vecs[v].name, ".idle_done"}, 64'(done), 64'd0);
      end

      // Reset at entry 10 aborts the dump; reset outranks the pending handshake.
      begin
         int cyc = 0;
         int seen_done = 0;
         fill_regs(0);
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0; out_ready = 1'b1;
         while (cyc < BUDGET && !(out_valid && out_index == 5'd10)) begin
            @(posedge clk); #1;
            cyc++;
         end
         check("abort.reach10", 64'(cyc < BUDGET), 64'd1);
         rst = 1'b1; start = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0; start = 1'b0;
         check("abort.valid", 64'(out_valid), 64'd0);
         check("abort.busy", 64'(busy), 64'd0);
         check("abort.chk", 64'(checksum), 64'd0);
         check("abort.index", 64'(out_index), 64'd0);
         for (int i = 0; i < 6; i++) begin
            if (done || busy) seen_done++;
            @(posedge clk); #1;
         end
         check("abort.no_done", 64'(seen_done), 64'd0);
         do_dump(0, -1);
         check_entries("after_abort");
         check("after_abort.chk", 64'(checksum), 64'(chk_exp(32'h0000_020F)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
